// File: rtl/umi_fifo_mc_pkg.sv
// Shared constants and helpers for the multi-channel UMI FIFO.
package umi_fifo_mc_pkg;

   localparam int unsigned UMI_EOMBIT = 22;

   function automatic int unsigned level_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

   // First requesting channel at or after ptr, wrapping; returns ptr when nothing requests.
   function automatic int unsigned rr_next_grant(input logic [31:0] req,
                                                 input int unsigned nch,
                                                 input int unsigned ptr);
      int unsigned idx;
      int unsigned res;
      res = ptr;
      for (int unsigned k = 32; k > 0; k--) begin
         if (k <= nch) begin
            idx = ptr + k - 1;
            if (idx >= nch) idx = idx - nch;
            if (req[idx[4:0]]) res = idx;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/umi_fifo_mc_chan.sv
// One input channel: circular storage, read/write pointers, level counter and registered flags.
module umi_fifo_mc_chan
   import umi_fifo_mc_pkg::*;
#(
   parameter int unsigned DW     = 128,
   parameter int unsigned AW     = 64,
   parameter int unsigned CW     = 32,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned AFULLT = 6,
   localparam int unsigned LW    = level_width(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_flush,
   input  logic          i_valid,
   input  logic [CW-1:0] i_cmd,
   input  logic [AW-1:0] i_dstaddr,
   input  logic [AW-1:0] i_srcaddr,
   input  logic [DW-1:0] i_data,
   output logic          o_ready,
   input  logic          i_pop,
   output logic [CW-1:0] o_cmd,
   output logic [AW-1:0] o_dstaddr,
   output logic [AW-1:0] o_srcaddr,
   output logic [DW-1:0] o_data,
   output logic [LW-1:0] o_level,
   output logic          o_afull,
   output logic          o_empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned EW = CW + 2 * AW + DW;

   logic [EW-1:0] r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [LW-1:0] r_level;
   logic [LW-1:0] w_level_nxt;
   logic          r_full;
   logic          r_afull;
   logic          r_empty;
   logic          w_push;
   logic          w_pop;

   // Ready is a function of registered state only; the downstream ready never reaches it.
   assign o_ready = !r_full && !i_reset && !i_flush;
   assign w_push  = i_valid && o_ready;
   assign w_pop   = i_pop && !r_empty;

   always_comb begin
      w_level_nxt = r_level;
      if (w_push && !w_pop) begin
         w_level_nxt = r_level + LW'(1);
      end else if (!w_push && w_pop) begin
         w_level_nxt = r_level - LW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset || i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_full  <= 1'b0;
         r_afull <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         r_level <= w_level_nxt;
         r_full  <= (w_level_nxt == LW'(DEPTH));
         r_afull <= (w_level_nxt >= LW'(AFULLT));
         r_empty <= (w_level_nxt == '0);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr] <= {i_cmd, i_dstaddr, i_srcaddr, i_data};
   end

   assign {o_cmd, o_dstaddr, o_srcaddr, o_data} = r_mem[r_rptr];
   assign o_level = r_level;
   assign o_afull = r_afull;
   assign o_empty = r_empty;

endmodule

// File: rtl/umi_fifo_mc.sv
// Multi-channel UMI buffer: per-channel FIFOs merged by a packet-atomic round-robin arbiter.
module umi_fifo_mc
   import umi_fifo_mc_pkg::*;
#(
   parameter int unsigned NCH    = 4,
   parameter int unsigned DW     = 128,
   parameter int unsigned AW     = 64,
   parameter int unsigned CW     = 32,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned AFULLT = 6,
   parameter int unsigned EOMBIT = UMI_EOMBIT,
   localparam int unsigned CHW   = $clog2(NCH),
   localparam int unsigned LW    = level_width(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NCH-1:0]    flush,
   input  logic [NCH-1:0]    umi_in_valid,
   input  logic [NCH*CW-1:0] umi_in_cmd,
   input  logic [NCH*AW-1:0] umi_in_dstaddr,
   input  logic [NCH*AW-1:0] umi_in_srcaddr,
   input  logic [NCH*DW-1:0] umi_in_data,
   output logic [NCH-1:0]    umi_in_ready,
   output logic              umi_out_valid,
   output logic [CW-1:0]     umi_out_cmd,
   output logic [AW-1:0]     umi_out_dstaddr,
   output logic [AW-1:0]     umi_out_srcaddr,
   output logic [DW-1:0]     umi_out_data,
   output logic [CHW-1:0]    umi_out_chan,
   input  logic              umi_out_ready,
   output logic [NCH*LW-1:0] fifo_level,
   output logic [NCH-1:0]    fifo_afull,
   output logic [NCH-1:0]    fifo_empty
);

   logic [CW-1:0]  w_cmd [NCH];
   logic [AW-1:0]  w_dst [NCH];
   logic [AW-1:0]  w_src [NCH];
   logic [DW-1:0]  w_data [NCH];
   logic [NCH-1:0] w_empty;
   logic [NCH-1:0] w_pop;
   logic [31:0]    w_req;
   logic [CHW-1:0] w_grant;
   logic           w_xfer;
   logic [CHW-1:0] r_rr;
   logic [CHW-1:0] r_gch;
   logic           r_lock;
   logic           r_hold;

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      umi_fifo_mc_chan #(
         .DW     (DW),
         .AW     (AW),
         .CW     (CW),
         .DEPTH  (DEPTH),
         .AFULLT (AFULLT)
      ) u_chan (
         .i_clk     (clk),
         .i_reset   (reset),
         .i_flush   (flush[i]),
         .i_valid   (umi_in_valid[i]),
         .i_cmd     (umi_in_cmd[i*CW +: CW]),
         .i_dstaddr (umi_in_dstaddr[i*AW +: AW]),
         .i_srcaddr (umi_in_srcaddr[i*AW +: AW]),
         .i_data    (umi_in_data[i*DW +: DW]),
         .o_ready   (umi_in_ready[i]),
         .i_pop     (w_pop[i]),
         .o_cmd     (w_cmd[i]),
         .o_dstaddr (w_dst[i]),
         .o_srcaddr (w_src[i]),
         .o_data    (w_data[i]),
         .o_level   (fifo_level[i*LW +: LW]),
         .o_afull   (fifo_afull[i]),
         .o_empty   (w_empty[i])
      );
   end

   assign fifo_empty = w_empty;

   // A packet lock or a stalled beat pins the grant so the output stays stable.
   always_comb begin
      w_req          = '0;
      w_req[NCH-1:0] = ~w_empty;
      if (r_lock || r_hold) begin
         w_grant = r_gch;
      end else begin
         w_grant = CHW'(rr_next_grant(w_req, NCH, 32'(r_rr)));
      end
   end

   assign umi_out_valid   = !w_empty[w_grant];
   assign umi_out_chan    = w_grant;
   assign umi_out_cmd     = w_cmd[w_grant];
   assign umi_out_dstaddr = w_dst[w_grant];
   assign umi_out_srcaddr = w_src[w_grant];
   assign umi_out_data    = w_data[w_grant];
   assign w_xfer          = umi_out_valid && umi_out_ready;

   always_comb begin
      w_pop          = '0;
      w_pop[w_grant] = w_xfer;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rr   <= '0;
         r_gch  <= '0;
         r_lock <= 1'b0;
         r_hold <= 1'b0;
      end else begin
         r_gch  <= w_grant;
         r_hold <= umi_out_valid && !umi_out_ready && !flush[w_grant];
         if (w_xfer) begin
            r_rr   <= (w_grant == CHW'(NCH - 1)) ? '0 : w_grant + CHW'(1);
            r_lock <= !umi_out_cmd[EOMBIT];
         end
         // Flushing the locked channel abandons the rest of its packet.
         if (flush[w_grant]) r_lock <= 1'b0;
      end
   end

endmodule

// File: tb/tb_umi_fifo_mc.sv
// Scenario bench for umi_fifo_mc: per-channel scoreboard queues plus arbitration-order checks.
module tb_umi_fifo_mc;

   localparam int unsigned NCH  = 4;
   localparam int unsigned DW   = 128;
   localparam int unsigned AW   = 64;
   localparam int unsigned CW   = 32;
   localparam int unsigned LW   = 4;
   localparam int unsigned CHW  = 2;
   localparam int unsigned EOMB = 22;

   typedef struct packed {
      logic [CW-1:0] cmd;
      logic [AW-1:0] dst;
      logic [AW-1:0] src;
      logic [DW-1:0] data;
   } beat_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [NCH-1:0]    flush = '0;
   logic [NCH-1:0]    in_valid = '0;
   logic [NCH*CW-1:0] in_cmd = '0;
   logic [NCH*AW-1:0] in_dst = '0;
   logic [NCH*AW-1:0] in_src = '0;
   logic [NCH*DW-1:0] in_data = '0;
   logic [NCH-1:0]    umi_in_ready;
   logic              umi_out_valid;
   logic [CW-1:0]     umi_out_cmd;
   logic [AW-1:0]     umi_out_dstaddr;
   logic [AW-1:0]     umi_out_srcaddr;
   logic [DW-1:0]     umi_out_data;
   logic [CHW-1:0]    umi_out_chan;
   logic              umi_out_ready = 1'b0;
   logic [NCH*LW-1:0] fifo_level;
   logic [NCH-1:0]    fifo_afull;
   logic [NCH-1:0]    fifo_empty;

   beat_t       sb [NCH][$];
   int unsigned out_log[$];
   beat_t       staged [NCH];
   int          n_tests = 0;
   int          n_fail = 0;
   int unsigned mon_c;
   beat_t       mon_e;

   umi_fifo_mc u_dut (
      .clk             (clk),
      .reset           (reset),
      .flush           (flush),
      .umi_in_valid    (in_valid),
      .umi_in_cmd      (in_cmd),
      .umi_in_dstaddr  (in_dst),
      .umi_in_srcaddr  (in_src),
      .umi_in_data     (in_data),
      .umi_in_ready    (umi_in_ready),
      .umi_out_valid   (umi_out_valid),
      .umi_out_cmd     (umi_out_cmd),
      .umi_out_dstaddr (umi_out_dstaddr),
      .umi_out_srcaddr (umi_out_srcaddr),
      .umi_out_data    (umi_out_data),
      .umi_out_chan    (umi_out_chan),
      .umi_out_ready   (umi_out_ready),
      .fifo_level      (fifo_level),
      .fifo_afull      (fifo_afull),
      .fifo_empty      (fifo_empty)
   );

   always #5 clk = ~clk;

   // Every output transfer is checked against the head of its channel's expected queue.
   always @(negedge clk) begin
      if (!reset && umi_out_valid && umi_out_ready) begin
         mon_c = 32'(umi_out_chan);
         out_log.push_back(mon_c);
         n_tests++;
         if (sb[mon_c].size() == 0) begin
            n_fail++;
            $display("FAIL beat_unexpected: ch%0d produced a beat, required none", mon_c);
         end else begin
            mon_e = sb[mon_c].pop_front();
            if ({umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data} !== mon_e) begin
               n_fail++;
               $display("FAIL beat_fields ch%0d: got cmd=%h data=%h, required cmd=%h data=%h",
                        mon_c, umi_out_cmd, umi_out_data, mon_e.cmd, mon_e.data);
            end
         end
      end
   end

   function automatic beat_t mk(input bit eom);
      beat_t b;
      b.cmd       = $urandom();
      b.cmd[EOMB] = eom;
      b.dst       = {$urandom(), $urandom()};
      b.src       = {$urandom(), $urandom()};
      b.data      = {$urandom(), $urandom(), $urandom(), $urandom()};
      return b;
   endfunction

   function automatic logic [LW-1:0] lvl(input int ch);
      return fifo_level[ch*LW +: LW];
   endfunction

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic stage(input int ch, input beat_t b);
      in_cmd[ch*CW +: CW]  = b.cmd;
      in_dst[ch*AW +: AW]  = b.dst;
      in_src[ch*AW +: AW]  = b.src;
      in_data[ch*DW +: DW] = b.data;
      in_valid[ch]         = 1'b1;
      staged[ch]           = b;
   endtask

   // Waits for all staged channels to be ready, records them, and ends just after the push edge.
   task automatic commit();
      bit ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge clk);
         if ((umi_in_ready & in_valid) == in_valid) ok = 1'b1;
      end
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL push_timeout: ready=%b, required ready on %b", umi_in_ready, in_valid);
      end else begin
         for (int c = 0; c < NCH; c++) if (in_valid[c]) sb[c].push_back(staged[c]);
      end
      sync();
      in_valid = '0;
   endtask

   task automatic drain();
      bit done = 1'b0;
      int left = 0;
      umi_out_ready = 1'b1;
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge clk);
         if (&fifo_empty && !umi_out_valid) done = 1'b1;
      end
      n_tests++;
      if (!done) begin
         n_fail++;
         $display("FAIL drain_timeout: empty=%b valid=%b, required all empty", fifo_empty,
                  umi_out_valid);
      end
      for (int c = 0; c < NCH; c++) left += sb[c].size();
      n_tests++;
      if (left != 0) begin
         n_fail++;
         $display("FAIL sb_leftover: %0d beats never delivered, required 0", left);
      end
      sync();
      umi_out_ready = 1'b0;
   endtask

   task automatic do_reset();
      sync();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int c = 0; c < NCH; c++) sb[c].delete();
      out_log.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      umi_out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (umi_in_ready !== 4'h0) begin
         n_fail++; $display("FAIL ready_in_reset: got %b, required 0000", umi_in_ready);
      end
      sync();
      reset = 1'b0;
      @(negedge clk);
      n_tests++;
      if (umi_in_ready !== 4'hF) begin
         n_fail++; $display("FAIL ready_after_reset: got %b, required 1111", umi_in_ready);
      end
      n_tests++;
      if (fifo_level !== '0) begin
         n_fail++; $display("FAIL level_reset: got %h, required 0", fifo_level);
      end
      n_tests++;
      if (fifo_empty !== 4'hF || fifo_afull !== 4'h0) begin
         n_fail++;
         $display("FAIL flags_reset: empty=%b afull=%b, required 1111/0000", fifo_empty,
                  fifo_afull);
      end
      n_tests++;
      if (umi_out_valid !== 1'b0) begin
         n_fail++; $display("FAIL valid_reset: got %b, required 0", umi_out_valid);
      end
   endtask

   task automatic test_single();
      sync();
      umi_out_ready = 1'b1;
      stage(2, mk(1'b1));
      commit();
      @(negedge clk);
      n_tests++;
      if (umi_out_valid !== 1'b1 || umi_out_chan !== 2'd2) begin
         n_fail++;
         $display("FAIL single_out: valid=%b chan=%0d, required 1/2", umi_out_valid, umi_out_chan);
      end
      n_tests++;
      if (lvl(2) !== 4'd1) begin
         n_fail++; $display("FAIL single_level1: got %0d, required 1", lvl(2));
      end
      @(negedge clk);
      n_tests++;
      if (lvl(2) !== 4'd0 || umi_out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_level0: level=%0d valid=%b, required 0/0", lvl(2), umi_out_valid);
      end
      sync();
      umi_out_ready = 1'b0;
   endtask

   task automatic test_fill();
      beat_t b9;
      bit held = 1'b1;
      sync();
      umi_out_ready = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         stage(0, mk(1'b1));
         commit();
         @(negedge clk);
         n_tests++;
         if (lvl(0) !== 4'(k) || fifo_afull[0] !== (k >= 6)) begin
            n_fail++;
            $display("FAIL fill_level k=%0d: level=%0d afull=%b, required %0d/%0d", k, lvl(0),
                     fifo_afull[0], k, (k >= 6));
         end
         sync();
      end
      n_tests++;
      if (umi_in_ready[0] !== 1'b0) begin
         n_fail++; $display("FAIL fill_full_ready: got %b, required 0", umi_in_ready[0]);
      end
      b9 = mk(1'b1);
      stage(0, b9);
      repeat (3) begin
         @(negedge clk);
         if (umi_in_ready[0] !== 1'b0 || lvl(0) !== 4'd8) held = 1'b0;
      end
      n_tests++;
      if (!held) begin
         n_fail++; $display("FAIL fill_ninth_held: level=%0d, required 8 and ready low", lvl(0));
      end
      sync();
      umi_out_ready = 1'b1;
      @(negedge clk);
      sync();
      umi_out_ready = 1'b0;
      @(negedge clk);
      n_tests++;
      if (umi_in_ready[0] !== 1'b1 || lvl(0) !== 4'd7) begin
         n_fail++;
         $display("FAIL fill_ready_after_pop: ready=%b level=%0d, required 1/7", umi_in_ready[0],
                  lvl(0));
      end
      sb[0].push_back(b9);
      sync();
      in_valid = '0;
      @(negedge clk);
      n_tests++;
      if (lvl(0) !== 4'd8) begin
         n_fail++; $display("FAIL fill_refill: level=%0d, required 8", lvl(0));
      end
      sync();
      drain();
   endtask

   task automatic test_round_robin();
      do_reset();
      umi_out_ready = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         for (int j = 0; j < 2; j++) begin
            stage(c, mk(1'b1));
            commit();
         end
      end
      out_log.delete();
      drain();
      for (int i = 0; i < 8; i++) begin
         n_tests++;
         if (i >= out_log.size() || out_log[i] != 32'(i % 4)) begin
            n_fail++;
            $display("FAIL rr_order[%0d]: got %0d, required %0d", i,
                     (i < out_log.size()) ? out_log[i] : 99, i % 4);
         end
      end
   endtask

   task automatic test_packet_lock();
      int unsigned exp[4] = '{1, 1, 1, 0};
      sync();
      out_log.delete();
      umi_out_ready = 1'b1;
      stage(1, mk(1'b0));
      commit();
      stage(0, mk(1'b1));
      commit();
      for (int g = 0; g < 4; g++) begin
         @(negedge clk);
         n_tests++;
         if (umi_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_gap[%0d]: valid=%b chan=%0d, required valid 0", g, umi_out_valid,
                     umi_out_chan);
         end
      end
      sync();
      stage(1, mk(1'b0));
      commit();
      stage(1, mk(1'b1));
      commit();
      drain();
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (i >= out_log.size() || out_log[i] != exp[i]) begin
            n_fail++;
            $display("FAIL lock_order[%0d]: got %0d, required %0d", i,
                     (i < out_log.size()) ? out_log[i] : 99, exp[i]);
         end
      end
   endtask

   task automatic test_flush();
      sync();
      umi_out_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         stage(3, mk(1'b0));
         commit();
      end
      umi_out_ready = 1'b1;
      @(negedge clk);
      sync();
      umi_out_ready = 1'b0;
      stage(0, mk(1'b1));
      commit();
      @(negedge clk);
      n_tests++;
      if (umi_out_valid !== 1'b1 || umi_out_chan !== 2'd3 || lvl(3) !== 4'd5 ||
          umi_in_ready[3] !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_pre: valid=%b chan=%0d level=%0d ready=%b, required 1/3/5/1",
                  umi_out_valid, umi_out_chan, lvl(3), umi_in_ready[3]);
      end
      sync();
      flush[3] = 1'b1;
      @(negedge clk);
      n_tests++;
      if (umi_in_ready[3] !== 1'b0) begin
         n_fail++; $display("FAIL flush_ready_low: got %b, required 0", umi_in_ready[3]);
      end
      sync();
      flush[3] = 1'b0;
      sb[3].delete();
      out_log.delete();
      @(negedge clk);
      n_tests++;
      if (lvl(3) !== 4'd0 || fifo_empty[3] !== 1'b1 || umi_in_ready[3] !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_post: level=%0d empty=%b ready=%b, required 0/1/1", lvl(3),
                  fifo_empty[3], umi_in_ready[3]);
      end
      n_tests++;
      if (umi_out_valid !== 1'b1 || umi_out_chan !== 2'd0) begin
         n_fail++;
         $display("FAIL flush_regrant: valid=%b chan=%0d, required 1/0", umi_out_valid,
                  umi_out_chan);
      end
      sync();
      drain();
      n_tests++;
      if (out_log.size() != 1 || out_log[0] != 0) begin
         n_fail++; $display("FAIL flush_log: got %0d beats, required one ch0 beat", out_log.size());
      end
   endtask

   task automatic test_reset_mid();
      sync();
      umi_out_ready = 1'b0;
      stage(2, mk(1'b0));
      commit();
      stage(2, mk(1'b1));
      commit();
      stage(1, mk(1'b1));
      stage(0, mk(1'b1));
      stage(3, mk(1'b1));
      commit();
      umi_out_ready = 1'b1;
      @(negedge clk);
      sync();
      umi_out_ready = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int c = 0; c < NCH; c++) sb[c].delete();
      @(negedge clk);
      n_tests++;
      if (fifo_level !== '0 || fifo_empty !== 4'hF || umi_out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_state: level=%h empty=%b valid=%b, required 0/1111/0",
                  fifo_level, fifo_empty, umi_out_valid);
      end
      n_tests++;
      if (umi_in_ready !== 4'hF) begin
         n_fail++; $display("FAIL midreset_ready: got %b, required 1111", umi_in_ready);
      end
      sync();
      out_log.delete();
      umi_out_ready = 1'b1;
      stage(3, mk(1'b1));
      stage(0, mk(1'b1));
      commit();
      drain();
      n_tests++;
      if (out_log.size() != 2 || out_log[0] != 0 || out_log[1] != 3) begin
         n_fail++;
         $display("FAIL midreset_grant: got %0d beats first ch%0d, required ch0 then ch3",
                  out_log.size(), (out_log.size() > 0) ? out_log[0] : 99);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_round_robin();
      test_packet_lock();
      test_flush();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
